// File: rtl/dmem_ctrl.sv
// Data memory controller: load/store request issue with retry on rejection
// and a small MSHR file that matches returning load data by tag.
module dmem_ctrl #(
  parameter int MSHR_SZ = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_load,
  input  logic [31:0]      Dmem_addr,
  input  logic             start_store,
  input  logic [31:0]      store_addr,
  input  logic [63:0]      store_data,
  input  logic [TAG_W-1:0] mem2proc_transaction_tag,
  input  logic [TAG_W-1:0] mem2proc_data_tag,
  input  logic [63:0]      mem2proc_data,
  output logic [1:0]       proc2mem_command,
  output logic [31:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic             dm_stalled,
  output logic             Dmem_data_ready,
  output logic [31:0]      Dmem_base_addr,
  output logic [63:0]      Dmem_load_data
);

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] RETRY = 1'b1;

  localparam int IDX_W = (MSHR_SZ > 1) ? $clog2(MSHR_SZ) : 1;

  logic [0:0]         state;
  logic [1:0]         r_cmd;
  logic [31:0]        r_addr;
  logic [63:0]        r_data;

  logic [MSHR_SZ-1:0] m_valid;
  logic [TAG_W-1:0]   m_tag  [MSHR_SZ];
  logic [31:0]        m_addr [MSHR_SZ];

  logic [63:0]        req_data;
  logic               reject;
  logic               alloc;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [MSHR_SZ-1:0] clr_mask;
  logic [MSHR_SZ-1:0] post_valid;
  logic [MSHR_SZ-1:0] alloc_mask;

  assign dm_stalled = (state == RETRY) | (&m_valid);

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    req_data         = '0;
    if (state == RETRY) begin
      proc2mem_command = r_cmd;
      proc2mem_addr    = r_addr;
      req_data         = r_data;
    end else if (!dm_stalled) begin
      if (start_store) begin
        proc2mem_command = MEM_STORE;
        proc2mem_addr    = store_addr;
        req_data         = store_data;
      end else if (start_load) begin
        proc2mem_command = MEM_LOAD;
        proc2mem_addr    = Dmem_addr;
      end
    end
  end

  assign proc2mem_data =
    (proc2mem_command == MEM_STORE) ? req_data : '0;

  assign reject = (proc2mem_command != MEM_NONE) &&
                  (mem2proc_transaction_tag == '0);
  assign alloc  = (proc2mem_command == MEM_LOAD) &&
                  (mem2proc_transaction_tag != '0);

  // Match only pre-existing entries, so a same-cycle allocate never hits.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    clr_mask = '0;
    for (int i = 0; i < MSHR_SZ; i++) begin
      if (!hit && m_valid[i] && mem2proc_data_tag != '0 &&
          m_tag[i] == mem2proc_data_tag) begin
        hit         = 1'b1;
        hit_idx     = IDX_W'(i);
        clr_mask[i] = 1'b1;
      end
    end
  end

  assign post_valid = m_valid & ~clr_mask;

  always_comb begin
    alloc_mask = '0;
    if (alloc) begin
      for (int i = MSHR_SZ - 1; i >= 0; i--) begin
        if (!post_valid[i]) begin
          alloc_mask    = '0;
          alloc_mask[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= READY;
      r_cmd           <= MEM_NONE;
      r_addr          <= '0;
      r_data          <= '0;
      m_valid         <= '0;
      Dmem_data_ready <= 1'b0;
      Dmem_base_addr  <= '0;
      Dmem_load_data  <= '0;
      for (int i = 0; i < MSHR_SZ; i++) begin
        m_tag[i]  <= '0;
        m_addr[i] <= '0;
      end
    end else begin
      if (reject) begin
        state  <= RETRY;
        r_cmd  <= proc2mem_command;
        r_addr <= proc2mem_addr;
        r_data <= proc2mem_data;
      end else if (state == RETRY) begin
        state  <= READY;
        r_cmd  <= MEM_NONE;
        r_addr <= '0;
        r_data <= '0;
      end
      m_valid <= post_valid | alloc_mask;
      for (int i = 0; i < MSHR_SZ; i++) begin
        if (alloc_mask[i]) begin
          m_tag[i]  <= mem2proc_transaction_tag;
          m_addr[i] <= proc2mem_addr;
        end
      end
      Dmem_data_ready <= hit;
      Dmem_base_addr  <= hit ? m_addr[hit_idx] : '0;
      Dmem_load_data  <= hit ? mem2proc_data : '0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus a randomized run checked
// against a tag-keyed model of outstanding loads.
module tb_dmem_ctrl;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam int NSLOT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_load;
  logic [31:0] Dmem_addr;
  logic        start_store;
  logic [31:0] store_addr;
  logic [63:0] store_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [3:0]  mem2proc_data_tag;
  logic [63:0] mem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic        dm_stalled;
  logic        Dmem_data_ready;
  logic [31:0] Dmem_base_addr;
  logic [63:0] Dmem_load_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_ctrl dut (
    .clock                    (clock),
    .reset                    (reset),
    .start_load               (start_load),
    .Dmem_addr                (Dmem_addr),
    .start_store              (start_store),
    .store_addr               (store_addr),
    .store_data               (store_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .mem2proc_data            (mem2proc_data),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .dm_stalled               (dm_stalled),
    .Dmem_data_ready          (Dmem_data_ready),
    .Dmem_base_addr           (Dmem_base_addr),
    .Dmem_load_data           (Dmem_load_data)
  );

  task automatic idle();
    reset = 1'b0;
    start_load = 1'b0;
    Dmem_addr = '0;
    start_store = 1'b0;
    store_addr = '0;
    store_data = '0;
    mem2proc_transaction_tag = '0;
    mem2proc_data_tag = '0;
    mem2proc_data = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();
    #1;
    checks++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, dm_stalled,
         Dmem_data_ready, Dmem_base_addr, Dmem_load_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs cmd=%0d addr=%h data=%h stall=%0b rdy=%0b base=%h ld=%h required all 0",
               proc2mem_command, proc2mem_addr, proc2mem_data, dm_stalled,
               Dmem_data_ready, Dmem_base_addr, Dmem_load_data);
    end
  endtask

  task automatic test_load_hit();
    idle();
    start_load = 1'b1;
    Dmem_addr = 32'h1008;
    mem2proc_transaction_tag = 4'd3;
    #1;
    checks++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data} !==
        {MEM_LOAD, 32'h1008, 64'h0}) begin
      errors++;
      $display("FAIL hit_issue cmd=%0d addr=%h data=%h required cmd=1 addr=1008 data=0",
               proc2mem_command, proc2mem_addr, proc2mem_data);
    end
    tick();
    idle();
    tick();
    mem2proc_data_tag = 4'd3;
    mem2proc_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    idle();
    checks++;
    if ({Dmem_data_ready, Dmem_base_addr, Dmem_load_data} !==
        {1'b1, 32'h1008, 64'hDEADBEEF_CAFEF00D}) begin
      errors++;
      $display("FAIL hit_data rdy=%0b base=%h ld=%h required 1 1008 deadbeefcafef00d",
               Dmem_data_ready, Dmem_base_addr, Dmem_load_data);
    end
    tick();
    checks++;
    if ({Dmem_data_ready, Dmem_base_addr, Dmem_load_data} !== '0) begin
      errors++;
      $display("FAIL hit_pulse_end rdy=%0b base=%h ld=%h required all 0",
               Dmem_data_ready, Dmem_base_addr, Dmem_load_data);
    end
  endtask

  task automatic test_retry();
    idle();
    start_load = 1'b1;
    Dmem_addr = 32'h2000;
    tick();
    for (int k = 0; k < 2; k++) begin
      idle();
      start_store = 1'b1;
      store_addr = 32'h3000;
      store_data = 64'h1111;
      mem2proc_transaction_tag = (k == 1) ? 4'd5 : 4'd0;
      #1;
      checks++;
      if ({dm_stalled, proc2mem_command, proc2mem_addr, proc2mem_data} !==
          {1'b1, MEM_LOAD, 32'h2000, 64'h0}) begin
        errors++;
        $display("FAIL retry_drive%0d stall=%0b cmd=%0d addr=%h data=%h required 1 1 2000 0",
                 k, dm_stalled, proc2mem_command, proc2mem_addr, proc2mem_data);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (dm_stalled !== 1'b0) begin
      errors++;
      $display("FAIL retry_release stall=%0b required 0", dm_stalled);
    end
    mem2proc_data_tag = 4'd5;
    mem2proc_data = 64'h55;
    tick();
    idle();
    checks++;
    if ({Dmem_data_ready, Dmem_base_addr} !== {1'b1, 32'h2000}) begin
      errors++;
      $display("FAIL retry_entry rdy=%0b base=%h required 1 2000",
               Dmem_data_ready, Dmem_base_addr);
    end
    tick();
  endtask

  task automatic test_full();
    logic [3:0] drain [3];
    drain = '{4'd1, 4'd3, 4'd4};
    for (int i = 1; i <= 4; i++) begin
      idle();
      start_load = 1'b1;
      Dmem_addr = 32'(i) << 8;
      mem2proc_transaction_tag = 4'(i);
      tick();
    end
    idle();
    start_load = 1'b1;
    Dmem_addr = 32'h900;
    mem2proc_transaction_tag = 4'd9;
    #1;
    checks++;
    if ({dm_stalled, proc2mem_command} !== {1'b1, MEM_NONE}) begin
      errors++;
      $display("FAIL full_stall stall=%0b cmd=%0d required 1 0",
               dm_stalled, proc2mem_command);
    end
    idle();
    mem2proc_data_tag = 4'd2;
    mem2proc_data = 64'h22;
    tick();
    idle();
    checks++;
    if ({dm_stalled, Dmem_data_ready, Dmem_base_addr} !==
        {1'b0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL full_free stall=%0b rdy=%0b base=%h required 0 1 200",
               dm_stalled, Dmem_data_ready, Dmem_base_addr);
    end
    for (int i = 0; i < 3; i++) begin
      mem2proc_data_tag = drain[i];
      tick();
      idle();
      checks++;
      if (Dmem_base_addr !== (32'(drain[i]) << 8)) begin
        errors++;
        $display("FAIL full_drain%0d base=%h required %h",
                 i, Dmem_base_addr, 32'(drain[i]) << 8);
      end
    end
    tick();
  endtask

  task automatic test_priority();
    idle();
    start_load = 1'b1;
    Dmem_addr = 32'h4000;
    start_store = 1'b1;
    store_addr = 32'h5008;
    store_data = 64'h0123_4567_89AB_CDEF;
    mem2proc_transaction_tag = 4'd6;
    #1;
    checks++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data} !==
        {MEM_STORE, 32'h5008, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL prio_store cmd=%0d addr=%h data=%h required 2 5008 0123456789abcdef",
               proc2mem_command, proc2mem_addr, proc2mem_data);
    end
    tick();
    idle();
    mem2proc_data_tag = 4'd6;
    tick();
    idle();
    checks++;
    if ({Dmem_data_ready, dm_stalled} !== 2'b00) begin
      errors++;
      $display("FAIL prio_no_entry rdy=%0b stall=%0b required 0 0",
               Dmem_data_ready, dm_stalled);
    end
  endtask

  task automatic test_stray_reset();
    idle();
    mem2proc_data_tag = 4'd7;
    mem2proc_data = 64'h77;
    tick();
    idle();
    checks++;
    if (Dmem_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL stray rdy=%0b required 0", Dmem_data_ready);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      start_load = 1'b1;
      Dmem_addr = 32'h6000 + 32'(i * 8);
      mem2proc_transaction_tag = 4'(8 + i);
      tick();
    end
    idle();
    mem2proc_data_tag = 4'd8;
    reset = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, dm_stalled,
         Dmem_data_ready, Dmem_base_addr, Dmem_load_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset cmd=%0d stall=%0b rdy=%0b base=%h required all 0",
               proc2mem_command, dm_stalled, Dmem_data_ready, Dmem_base_addr);
    end
    for (int i = 0; i < 2; i++) begin
      mem2proc_data_tag = 4'(8 + i);
      tick();
      idle();
      checks++;
      if (Dmem_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_tag%0d rdy=%0b required 0",
                 8 + i, Dmem_data_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] outq [int];
    bit          m_retry;
    logic [1:0]  m_cmd;
    logic [31:0] m_addr;
    logic [63:0] m_data;
    bit          e_rdy;
    logic [31:0] e_base;
    logic [63:0] e_ld;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_pd;
    bit          e_stall;
    int          r;
    int          pick;
    idle();
    reset = 1'b1;
    tick();
    m_retry = 0;
    m_cmd = MEM_NONE;
    m_addr = '0;
    m_data = '0;
    e_rdy = 0;
    e_base = '0;
    e_ld = '0;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 80) == 0);
      start_load = 1'($urandom_range(0, 1));
      start_store = ($urandom_range(0, 3) == 0);
      Dmem_addr = $urandom & 32'hFFFF_FFF8;
      store_addr = $urandom & 32'hFFFF_FFF8;
      store_data = {$urandom, $urandom};
      mem2proc_data = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) mem2proc_transaction_tag = '0;
      else begin
        do r = $urandom_range(1, 15); while (outq.exists(r));
        mem2proc_transaction_tag = 4'(r);
      end
      r = $urandom_range(0, 2);
      mem2proc_data_tag = '0;
      if (r == 1) mem2proc_data_tag = 4'($urandom_range(1, 15));
      if (r == 2 && outq.num() > 0) begin
        pick = $urandom_range(0, outq.num() - 1);
        foreach (outq[k]) begin
          if (pick == 0) mem2proc_data_tag = 4'(k);
          pick--;
        end
      end
      e_stall = m_retry || (outq.num() == NSLOT);
      e_cmd = MEM_NONE;
      e_addr = '0;
      e_pd = '0;
      if (m_retry) begin
        e_cmd = m_cmd;
        e_addr = m_addr;
        e_pd = m_data;
      end else if (!e_stall && start_store) begin
        e_cmd = MEM_STORE;
        e_addr = store_addr;
        e_pd = store_data;
      end else if (!e_stall && start_load) begin
        e_cmd = MEM_LOAD;
        e_addr = Dmem_addr;
      end
      #1;
      checks++;
      if ({proc2mem_command, proc2mem_addr, proc2mem_data, dm_stalled} !==
          {e_cmd, e_addr, e_pd, e_stall}) begin
        errors++;
        $display("FAIL rand_req%0d cmd=%0d addr=%h data=%h stall=%0b required %0d %h %h %0b",
                 c, proc2mem_command, proc2mem_addr, proc2mem_data, dm_stalled,
                 e_cmd, e_addr, e_pd, e_stall);
      end
      tick();
      if (reset) begin
        outq.delete();
        m_retry = 0;
        e_rdy = 0;
        e_base = '0;
        e_ld = '0;
      end else begin
        e_rdy = 0;
        e_base = '0;
        e_ld = '0;
        if (mem2proc_data_tag != 0 && outq.exists(int'(mem2proc_data_tag))) begin
          e_rdy = 1;
          e_base = outq[int'(mem2proc_data_tag)];
          e_ld = mem2proc_data;
          outq.delete(int'(mem2proc_data_tag));
        end
        if (e_cmd != MEM_NONE) begin
          if (mem2proc_transaction_tag == 0) begin
            m_retry = 1;
            m_cmd = e_cmd;
            m_addr = e_addr;
            m_data = e_pd;
          end else begin
            m_retry = 0;
            if (e_cmd == MEM_LOAD) outq[int'(mem2proc_transaction_tag)] = e_addr;
          end
        end
      end
      checks++;
      if ({Dmem_data_ready, Dmem_base_addr, Dmem_load_data} !==
          {e_rdy, e_base, e_ld}) begin
        errors++;
        $display("FAIL rand_resp%0d rdy=%0b base=%h ld=%h required %0b %h %h",
                 c, Dmem_data_ready, Dmem_base_addr, Dmem_load_data,
                 e_rdy, e_base, e_ld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_retry();
    test_full();
    test_priority();
    test_stray_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter MSHR_SZ, default 4, giving the number of outstanding load entries.
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the memory tag width; tag 0 SHALL mean "no tag".
REQ-003 clock  input  1  Rising-edge system clock.
REQ-004 reset  input  1  Synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 start_load  input  1  Load request strobe from the load FU.
REQ-006 Dmem_addr  input  32  Load address, 8-byte aligned, with bits [2:0]=0.
REQ-007 start_store  input  1  Store request strobe from the store path.
REQ-008 store_addr  input  32  Store address, 8-byte aligned.
REQ-009 store_data  input  64  Store block data.
REQ-010 mem2proc_transaction_tag  input  TAG_W  Memory acceptance tag for the request driven this cycle; 0 means rejected.
REQ-011 mem2proc_data_tag  input  TAG_W  Tag of the returning load data; 0 means no data.
REQ-012 mem2proc_data  input  64  Returning load data block.
REQ-013 proc2mem_command  output  2  Memory command: MEM_NONE, MEM_LOAD or MEM_STORE.
REQ-014 proc2mem_addr  output  32  Memory request address.
REQ-015 proc2mem_data  output  64  Store data; 0 when the command is not MEM_STORE.
REQ-016 dm_stalled  output  1  Back-pressure to the load FU and the store path.
REQ-017 Dmem_data_ready  output  1  One-cycle pulse indicating that load data is valid.
REQ-018 Dmem_base_addr  output  32  Aligned address of the returned load.
REQ-019 Dmem_load_data  output  64  Returned load block.

Function
REQ-020 The request FSM SHALL have two states: READY and RETRY.
REQ-021 In READY, the request source SHALL be chosen in this order:
- start_store drives MEM_STORE with store_addr and store_data.
- else start_load drives MEM_LOAD with Dmem_addr.
- else the command is MEM_NONE.
REQ-022 When start_store and start_load are both high, the store SHALL win and the load SHALL be ignored.
REQ-023 In READY, proc2mem_command, proc2mem_addr and proc2mem_data SHALL be combinational from the inputs, with zero added latency.
REQ-024 In READY, if dm_stalled is 1, start_load and start_store SHALL be ignored and the command SHALL be MEM_NONE.
REQ-025 When a non-NONE command sees mem2proc_transaction_tag==0, the block SHALL latch the command, address and data into a retry register and go to RETRY.
REQ-026 In RETRY, the block SHALL re-drive the latched request every cycle and SHALL ignore new strobes.
REQ-027 In RETRY, a nonzero mem2proc_transaction_tag SHALL return the FSM to READY on the next cycle.
REQ-028 A load accepted with nonzero tag t SHALL allocate the lowest-index free MSHR entry as {valid=1, tag=t, addr}.
REQ-029 An accepted store SHALL allocate no MSHR entry, and its tag SHALL be discarded.
REQ-030 dm_stalled SHALL equal (state==RETRY) OR (all MSHR_SZ entries valid).
REQ-031 dm_stalled SHALL be combinational from registered state only.
REQ-032 A nonzero mem2proc_data_tag matching a valid entry SHALL clear that entry.
REQ-033 On the next rising edge after such a match, the block SHALL register:
- Dmem_data_ready=1 for exactly one cycle;
- Dmem_base_addr = the entry's addr;
- Dmem_load_data = mem2proc_data.
REQ-034 When no response is being delivered, Dmem_data_ready SHALL be 0, Dmem_base_addr SHALL be 0 and Dmem_load_data SHALL be 0.
REQ-035 A nonzero mem2proc_data_tag matching no valid entry SHALL be ignored, with no pulse and no state change.
REQ-036 A free (response) and an allocate in the same cycle SHALL both take effect.
REQ-037 An entry freed in a cycle SHALL be reusable by an allocate in the same cycle; full is evaluated on post-free occupancy for the next cycle's dm_stalled.
REQ-038 A response whose tag equals the transaction tag being accepted in the same cycle SHALL match only an entry that already existed.
REQ-039 At most one response SHALL be delivered per cycle; multiple valid entries with the same tag SHALL NOT exist.

Reset
REQ-040 On reset, the FSM SHALL enter READY, all MSHR entries SHALL be invalid and the retry register SHALL be 0.
REQ-041 On reset, all outputs SHALL be 0 and proc2mem_command SHALL be MEM_NONE.
REQ-042 Reset asserted mid-transaction SHALL discard all outstanding loads.
REQ-043 Responses arriving after reset SHALL match no entry and SHALL be ignored.

Verification
REQ-044 Load hit path: start_load, Dmem_addr=0x1008, transaction_tag=3; two cycles later data_tag=3, data=0xDEADBEEF_CAFEF00D -> the next cycle Dmem_data_ready=1, Dmem_base_addr=0x1008, Dmem_load_data=0xDEADBEEF_CAFEF00D for one cycle.
REQ-045 Rejection/retry: start_load with addr 0x2000 and tag=0 for 2 cycles, then tag=5 -> dm_stalled=1 during the retry, MEM_LOAD 0x2000 re-driven each cycle, dm_stalled=0 the cycle after acceptance, and entry tag 5 held.
REQ-046 Full: 4 loads accepted with tags 1-4 -> dm_stalled=1; data_tag=2 -> dm_stalled=0 the next cycle, with the response carrying the addr of tag 2.
REQ-047 Priority: start_store and start_load in the same cycle -> MEM_STORE with store_addr/store_data is driven, and no MSHR entry is allocated.
REQ-048 Stray and reset: data_tag=7 with no entry -> no pulse; reset with 2 outstanding loads -> all outputs 0 and later matching tags ignored.
